// File: rtl/flash_loader.sv
// Boot-time SPI NOR to cache copy engine.
// Issues one 0x03 read, packs bytes little-endian, writes words to the cache.
`timescale 1ns/1ps

module flash_loader #(
    parameter logic [31:0] STARTUP_WAIT  = 32'd1_000_000,
    parameter logic [23:0] FLASH_ADDRESS = 24'h00_0000,
    parameter logic [31:0] CACHE_ADDRESS = 32'h0000_0000,
    parameter logic [31:0] BYTES_NUM     = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        flash_clk,
    output logic        flash_mosi,
    output logic        flash_cs,
    input  logic        flash_miso,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic [3:0]  cache_write_enable,
    input  logic        cache_busy,
    output logic        done
);

    typedef enum logic [2:0] {
        POWER_WAIT,
        SEND,
        READ,
        WRITE_ISSUE,
        WRITE_WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] word_q, word_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;

    logic        sck_d;
    logic        mosi_d;
    logic        cs_d;
    logic [31:0] addr_d;
    logic [31:0] data_d;
    logic [3:0]  we_d;
    logic        done_d;

    logic [7:0]  byte_next;
    logic [31:0] byte_cnt_inc;

    assign byte_next    = {byte_q[6:0], flash_miso};
    assign byte_cnt_inc = byte_cnt_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= POWER_WAIT;
            wait_cnt_q         <= '0;
            shift_q            <= '0;
            bit_cnt_q          <= '0;
            phase_q            <= 1'b0;
            byte_q             <= '0;
            word_q             <= '0;
            byte_cnt_q         <= '0;
            flash_clk          <= 1'b0;
            flash_mosi         <= 1'b0;
            flash_cs           <= 1'b1;
            cache_address      <= CACHE_ADDRESS;
            cache_data_in      <= '0;
            cache_write_enable <= '0;
            done               <= 1'b0;
        end else begin
            state_q            <= state_d;
            wait_cnt_q         <= wait_cnt_d;
            shift_q            <= shift_d;
            bit_cnt_q          <= bit_cnt_d;
            phase_q            <= phase_d;
            byte_q             <= byte_d;
            word_q             <= word_d;
            byte_cnt_q         <= byte_cnt_d;
            flash_clk          <= sck_d;
            flash_mosi         <= mosi_d;
            flash_cs           <= cs_d;
            cache_address      <= addr_d;
            cache_data_in      <= data_d;
            cache_write_enable <= we_d;
            done               <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        byte_d     = byte_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        sck_d      = flash_clk;
        mosi_d     = flash_mosi;
        cs_d       = flash_cs;
        addr_d     = cache_address;
        data_d     = cache_data_in;
        we_d       = cache_write_enable;
        done_d     = done;

        unique case (state_q)
            POWER_WAIT: begin
                if (wait_cnt_q == STARTUP_WAIT) begin
                    wait_cnt_d = '0;
                    shift_d    = {8'h03, FLASH_ADDRESS};
                    bit_cnt_d  = 6'd32;
                    phase_d    = 1'b0;
                    cs_d       = 1'b0;
                    state_d    = SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end

            SEND: begin
                if (!phase_q) begin
                    sck_d     = 1'b0;
                    mosi_d    = shift_q[31];
                    shift_d   = {shift_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 6'd1;
                    phase_d   = 1'b1;
                end else begin
                    sck_d   = 1'b1;
                    phase_d = 1'b0;
                    if (bit_cnt_q == 6'd0) begin
                        bit_cnt_d = 6'd32;
                        state_d   = READ;
                    end
                end
            end

            READ: begin
                if (!phase_q) begin
                    sck_d   = 1'b0;
                    phase_d = 1'b1;
                end else begin
                    sck_d     = 1'b1;
                    phase_d   = 1'b0;
                    byte_d    = byte_next;
                    bit_cnt_d = bit_cnt_q - 6'd1;
                    // Completed bytes enter at the top so the first lands in the LSB.
                    if (bit_cnt_q[2:0] == 3'd1) begin
                        word_d = {byte_next, word_q[31:8]};
                    end
                    if (bit_cnt_q == 6'd1) begin
                        state_d = WRITE_ISSUE;
                    end
                end
            end

            WRITE_ISSUE: begin
                if (!cache_busy) begin
                    data_d  = word_q;
                    we_d    = 4'b1111;
                    state_d = WRITE_WAIT;
                end
            end

            WRITE_WAIT: begin
                if (!cache_busy) begin
                    we_d       = 4'b0000;
                    addr_d     = cache_address + 32'd4;
                    byte_cnt_d = byte_cnt_inc;
                    bit_cnt_d  = 6'd32;
                    phase_d    = 1'b0;
                    if (byte_cnt_inc == BYTES_NUM) begin
                        cs_d    = 1'b1;
                        sck_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            DONE: begin
                done_d = 1'b1;
            end

            default: begin
                state_d = POWER_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_loader.sv
// Randomized bench for flash_loader: behavioural SPI flash and cache models.
// Writes are scored against words computed straight from the flash contents.
`timescale 1ns/1ps

module tb_flash_loader;

    localparam logic [31:0] SW = 32'd4;
    localparam logic [23:0] FA = 24'h12_3456;
    localparam logic [31:0] CA = 32'h0000_0100;
    localparam logic [31:0] BN = 32'd12;
    localparam int          NW = 3;
    localparam logic [71:0] RST_OUTS = {1'b0, 1'b0, 1'b1, CA, 32'h0, 4'h0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_cs;
    logic        flash_miso;
    logic [31:0] cache_address;
    logic [31:0] cache_data_in;
    logic [3:0]  cache_write_enable;
    logic        cache_busy = 1'b0;
    logic        done;

    flash_loader #(
        .STARTUP_WAIT (SW),
        .FLASH_ADDRESS(FA),
        .CACHE_ADDRESS(CA),
        .BYTES_NUM    (BN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flash_clk         (flash_clk),
        .flash_mosi        (flash_mosi),
        .flash_cs          (flash_cs),
        .flash_miso        (flash_miso),
        .cache_address     (cache_address),
        .cache_data_in     (cache_data_in),
        .cache_write_enable(cache_write_enable),
        .cache_busy        (cache_busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [71:0] outs;
    assign outs = {flash_clk, flash_mosi, flash_cs, cache_address,
                   cache_data_in, cache_write_enable, done};

    // SPI NOR model: 256-byte image, address wraps within the image.
    logic [7:0]  mem [256];
    int          r = 0;
    logic [31:0] cmd = '0;
    logic        model_miso = 1'b0;
    logic        junk_miso = 1'b0;
    int          dd;
    logic [23:0] fa_q;

    assign flash_miso = flash_cs ? junk_miso : model_miso;

    initial forever begin
        @(posedge flash_clk or negedge flash_cs);
        if (!flash_clk) begin
            r = 0;
            cmd = '0;
        end else if (!flash_cs) begin
            r++;
            if (r <= 32) cmd = {cmd[30:0], flash_mosi};
        end
    end

    initial forever begin
        @(negedge flash_clk);
        if (!flash_cs && r >= 32) begin
            dd = r - 32;
            fa_q = cmd[23:0] + 24'(dd / 8);
            model_miso = mem[fa_q[7:0]][7 - (dd % 8)];
        end
    end

    function automatic logic [31:0] exp_word(input int k);
        logic [23:0] a;
        logic [7:0]  b0, b1, b2, b3;
        a  = FA + 24'(4 * k);
        b0 = a[7:0];
        b1 = b0 + 8'd1;
        b2 = b0 + 8'd2;
        b3 = b0 + 8'd3;
        return {mem[b3], mem[b2], mem[b1], mem[b0]};
    endfunction

    // Cache model and write monitor.
    logic        busy_seen = 1'b0;
    logic        rst_seen = 1'b1;
    logic [3:0]  we_prev = '0;
    logic [31:0] addr_prev = '0;
    logic [31:0] data_prev = '0;
    logic        done_prev = 1'b0;
    int          force_cnt = 0;
    bit          stall_used = 1'b0;
    int          stall_mode = 0;
    bit          rand_busy = 1'b0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    initial forever begin
        @(posedge clk);
        busy_seen = cache_busy;
        rst_seen  = rst;
    end

    initial forever begin
        @(negedge clk);
        if (rst_seen) begin
            we_prev = '0;
            done_prev = 1'b0;
            stall_used = 1'b0;
            force_cnt = 0;
            wr_addr.delete();
            wr_data.delete();
        end else begin
            if (we_prev == 4'hf) begin
                check("we_hold", cache_write_enable, busy_seen ? 4'hf : 4'h0);
                check("sck_paused", flash_clk, !cache_write_enable[0] &&
                      wr_addr.size() == NW ? 1'b0 : 1'b1);
                if (cache_write_enable != 0) begin
                    check("addr_stable", cache_address, addr_prev);
                    check("data_stable", cache_data_in, data_prev);
                end else begin
                    check("addr_inc", cache_address, addr_prev + 32'd4);
                end
            end else if (cache_write_enable != 0) begin
                check("issue_gate", busy_seen, 1'b0);
                check("issue_we", cache_write_enable, 4'hf);
                check("issue_sck", r, 32 + 32 * (wr_addr.size() + 1));
                wr_addr.push_back(cache_address);
                wr_data.push_back(cache_data_in);
                if (stall_mode == 1 && !stall_used) begin
                    force_cnt = 10;
                    stall_used = 1'b1;
                end
            end
            if (done && !done_prev) begin
                check("done_cs", flash_cs, 1'b1);
                check("done_we", cache_write_enable, 4'h0);
            end
            if (stall_mode == 2 && !stall_used && r == 64 && flash_clk &&
                cache_write_enable == 0) begin
                force_cnt = 5;
                stall_used = 1'b1;
            end
            done_prev = done;
            we_prev   = cache_write_enable;
            addr_prev = cache_address;
            data_prev = cache_data_in;
        end
        if (force_cnt > 0) begin
            cache_busy = 1'b1;
            force_cnt--;
        end else begin
            cache_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    task automatic run_copy(input bit timed);
        int n;
        int cs_at;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outs", outs, RST_OUTS);
        rst = 1'b0;
        n = 0;
        cs_at = -1;
        while (!done && n < 4000) begin
            @(posedge clk);
            n++;
            #1;
            if (!flash_cs && cs_at < 0) cs_at = n;
        end
        check("done_seen", done, 1'b1);
        if (timed) begin
            check("cs_fall_cycle", cs_at, SW + 1);
            check("done_cycle", n, SW + 1 + 64 + 66 * NW);
        end
        check("cmd_bits", cmd, {8'h03, FA});
        check("n_writes", wr_addr.size(), NW);
        for (int k = 0; k < NW; k++) begin
            if (k < wr_addr.size()) begin
                check("wr_addr", wr_addr[k], CA + 32'(4 * k));
                check("wr_data", wr_data[k], exp_word(k));
            end
        end
        check("end_cs", flash_cs, 1'b1);
        check("end_sck", flash_clk, 1'b0);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0]  fixed [8];
        logic [71:0] snap;
        logic [23:0] a;
        int          target;
        int          n;

        fixed = '{8'h33, 8'h32, 8'h31, 8'h34, 8'h0a, 8'h61, 8'h62, 8'h63};
        randomize_mem();
        for (int i = 0; i < 8; i++) begin
            a = FA + 24'(i);
            mem[a[7:0]] = fixed[i];
        end

        repeat (3) @(negedge clk);
        check("reset_state", outs, RST_OUTS);

        run_copy(1'b1);
        if (wr_data.size() >= 2) begin
            check("basic_w0", wr_data[0], 32'h3431_3233);
            check("basic_w1", wr_data[1], 32'h6362_610a);
        end

        stall_mode = 1;
        randomize_mem();
        run_copy(1'b0);

        stall_mode = 2;
        randomize_mem();
        run_copy(1'b0);

        stall_mode = 0;
        rand_busy = 1'b1;
        for (int rep = 0; rep < 3; rep++) begin
            randomize_mem();
            run_copy(1'b0);
        end

        randomize_mem();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        target = 64 + $urandom_range(1, 31);
        n = 0;
        while (flash_cs && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (r < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", r, target);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_cs", flash_cs, 1'b1);
        check("mid_rst_we", cache_write_enable, 4'h0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_sck", flash_clk, 1'b0);
        run_copy(1'b0);

        snap = outs;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            junk_miso = 1'($urandom);
            @(posedge clk);
            #1;
            check("sticky", outs, snap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
